mosaic_tile_scheduler: RTL and testbench
========================================

Name: mosaic_tile_scheduler

Overview:
Frame-level controller that steps the stitching pipeline through a TILE_ROWS x TILE_COLS mosaic, one tile at a time. Per tile it issues a start strobe with tile coordinates, holds the pipeline enable, and waits for the pipeline's done. A per-tile watchdog catches hung tiles. The block sits between the host/frame trigger and the stitching datapath, and replaces free-running enable control with explicit per-tile sequencing.

Parameters:
TILE_ROWS, 4, tile rows per frame (>=1)
TILE_COLS, 4, tile columns per frame (>=1)
TIMEOUT_CYCLES, 1024, maximum WAIT cycles per tile before error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  frame start request, sampled in IDLE or ERROR only
abort  in  1  cancel current frame, any state
pipe_done  in  1  pipeline finished current tile, single-cycle pulse
pipe_en  out  1  pipeline enable
tile_start  out  1  one-cycle strobe at start of each tile
tile_row  out  ROW_W  current tile row, ROW_W = $clog2(max(TILE_ROWS,2))
tile_col  out  COL_W  current tile column, COL_W = $clog2(max(TILE_COLS,2))
tiles_done  out  CNT_W  tiles completed this frame, CNT_W = $clog2(TILE_ROWS*TILE_COLS+1)
busy  out  1  high in any state except IDLE and ERROR
frame_done  out  1  one-cycle pulse after last tile completes
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0. Row/col/tiles_done/timer = 0. Reset mid-frame drops pipe_en immediately. No frame_done is produced.
- All outputs are registered. The FSM states are IDLE, ISSUE, WAIT, NEXT, FINISH, ERROR.
- IDLE: start=1 -> ISSUE. On this transition, clear row, col, tiles_done and timer to 0. start held high is treated as one request per frame. A new frame begins only when start is seen again in IDLE.
- ISSUE (1 cycle): tile_start=1, pipe_en=1, timer cleared. Next state is WAIT.
- Latency: start sampled at edge N -> tile_start and pipe_en high in the cycle after edge N+1.
- WAIT: pipe_en=1 and timer increments each cycle.
  - pipe_done=1 -> NEXT and tiles_done+1.
  - timer == TIMEOUT_CYCLES-1 with no pipe_done -> ERROR.
  - If pipe_done and timeout occur in the same cycle, done wins.
- NEXT (1 cycle): pipe_en=0, which gives a drain gap between tiles.
  - col == TILE_COLS-1: col=0 and row+1. Otherwise col+1.
  - If the tile just completed was (TILE_ROWS-1, TILE_COLS-1) -> FINISH, with row/col left unchanged. Otherwise -> ISSUE.
- FINISH (1 cycle): frame_done=1 -> IDLE. tiles_done holds the final count (TILE_ROWS*TILE_COLS) until the next start.
- ERROR: pipe_en=0, busy=0, timeout_err=1 (held). tile_row/tile_col freeze on the hung tile.
  - start -> clear timeout_err and go to ISSUE with a fresh frame (row/col=0).
  - abort -> clear timeout_err and go to IDLE.
- abort=1 in ISSUE, WAIT, NEXT or FINISH -> IDLE next cycle, pipe_en=0, frame_done is not pulsed. abort has priority over pipe_done, timeout and start.
- pipe_done outside WAIT is ignored; no count change.
- start while busy is ignored.
- Degenerate 1x1 grid: a single ISSUE/WAIT/NEXT pass, then FINISH.
- tile_row/tile_col are valid while pipe_en=1 and stable for the whole tile.

Decomposition:
- Package mosaic_pkg holds:
  - the state enum typedef sched_state_t {IDLE, ISSUE, WAIT, NEXT, FINISH, ERROR};
  - default TILE_ROWS/TILE_COLS/TIMEOUT_CYCLES constants, shared with the datapath.
- One natural sub-module is tile_watchdog: a loadable up-counter with clear/enable inputs and an expired output at TIMEOUT_CYCLES-1. It is instantiated once.
- Row/col stepping stays inline.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, no start for 10 cycles -> all outputs 0, busy=0.
- Full frame, TILE_ROWS=2, TILE_COLS=3, with pipe_done 5 cycles after each tile_start:
  - 6 tile_start pulses with coordinates (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - pipe_en low exactly 1 cycle between tiles;
  - frame_done pulses once; tiles_done=6; busy falls the cycle after frame_done.
- Timeout, TIMEOUT_CYCLES=8: start, never assert pipe_done -> after 8 WAIT cycles timeout_err=1, pipe_en=0, tile=(0,0). Then start -> timeout_err=0 and tile_start with (0,0).
- Abort mid-frame: abort during WAIT of tile (0,2) -> IDLE next cycle, pipe_en=0, no frame_done, tiles_done=2.
- Simultaneous events:
  - pipe_done on the same cycle as timer expiry -> NEXT, no error;
  - abort with pipe_done -> IDLE, tiles_done unchanged;
  - stray pipe_done in IDLE -> ignored.
- Asynchronous reset mid-WAIT: reset=0 between clock edges -> pipe_en and busy drop without a clock edge; the next start begins at (0,0).

Source files
------------

// File: rtl/mosaic_pkg.sv
// Shared scheduler state type and default mosaic geometry, also used by the stitching datapath.
package mosaic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        FINISH,
        ERROR
    } sched_state_t;

    localparam int unsigned DEF_TILE_ROWS      = 4;
    localparam int unsigned DEF_TILE_COLS      = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/tile_watchdog.sv
// Per-tile watchdog: loadable up-counter that saturates and flags expiry at TIMEOUT_CYCLES-1.
module tile_watchdog
    import mosaic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_expired;

    assign w_expired = (r_count == LIMIT);
    assign o_expired = w_expired;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mosaic_tile_scheduler.sv
// Frame-level sequencer: walks the tile grid row-major, issuing one start/enable window per tile.
module mosaic_tile_scheduler
    import mosaic_pkg::*;
#(
    parameter int unsigned TILE_ROWS      = DEF_TILE_ROWS,
    parameter int unsigned TILE_COLS      = DEF_TILE_COLS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ROW_W          = $clog2((TILE_ROWS > 1) ? TILE_ROWS : 2),
    parameter int unsigned COL_W          = $clog2((TILE_COLS > 1) ? TILE_COLS : 2),
    parameter int unsigned CNT_W          = $clog2(TILE_ROWS * TILE_COLS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pipe_done,
    output logic             o_pipe_en,
    output logic             o_tile_start,
    output logic [ROW_W-1:0] o_tile_row,
    output logic [COL_W-1:0] o_tile_col,
    output logic [CNT_W-1:0] o_tiles_done,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_timeout_err
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILE_COLS - 1);
    localparam int unsigned      WD_W     = $clog2(TIMEOUT_CYCLES);

    sched_state_t     r_state, w_state_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic [COL_W-1:0] r_col, w_col_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_start_prev;
    logic             w_start_req;
    logic             w_wd_clear;
    logic             w_wd_en;
    logic             w_wd_expired;
    logic             w_last_col;
    logic             w_last_tile;

    logic             r_pipe_en, r_tile_start, r_busy, r_frame_done, r_timeout_err;
    logic [ROW_W-1:0] r_tile_row;
    logic [COL_W-1:0] r_tile_col;
    logic [CNT_W-1:0] r_tiles_done;

    // Rising-edge qualify so a start held high launches only one frame.
    assign w_start_req = i_start && !r_start_prev;
    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_tile = w_last_col && (r_row == LAST_ROW);

    tile_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (WD_W)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .i_load    (1'b0),
        .i_load_val('0),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_cnt_next   = r_cnt;
        w_wd_clear   = 1'b0;
        w_wd_en      = 1'b0;
        if (i_abort) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE, ERROR: begin
                    if (w_start_req) begin
                        w_state_next = ISSUE;
                        w_row_next   = '0;
                        w_col_next   = '0;
                        w_cnt_next   = '0;
                        w_wd_clear   = 1'b1;
                    end
                end
                ISSUE: begin
                    w_state_next = WAIT;
                    w_wd_clear   = 1'b1;
                end
                WAIT: begin
                    // Done is checked first so it wins over a same-cycle expiry.
                    if (i_pipe_done) begin
                        w_state_next = NEXT;
                        w_cnt_next   = r_cnt + 1'b1;
                    end else if (w_wd_expired) begin
                        w_state_next = ERROR;
                    end else begin
                        w_wd_en = 1'b1;
                    end
                end
                NEXT: begin
                    if (w_last_tile) begin
                        w_state_next = FINISH;
                    end else begin
                        w_state_next = ISSUE;
                        if (w_last_col) begin
                            w_col_next = '0;
                            w_row_next = r_row + 1'b1;
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end
                end
                FINISH: w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_cnt        <= '0;
            r_start_prev <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row        <= w_row_next;
            r_col        <= w_col_next;
            r_cnt        <= w_cnt_next;
            r_start_prev <= i_start;
        end
    end

    // Outputs are registered from the current state; abort masks them on the same edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pipe_en     <= 1'b0;
            r_tile_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tile_row    <= '0;
            r_tile_col    <= '0;
            r_tiles_done  <= '0;
        end else begin
            r_pipe_en     <= !i_abort && ((r_state == ISSUE) || (r_state == WAIT));
            r_tile_start  <= !i_abort && (r_state == ISSUE);
            r_busy        <= !i_abort && (r_state != IDLE) && (r_state != ERROR);
            r_frame_done  <= !i_abort && (r_state == FINISH);
            r_timeout_err <= (r_state == ERROR) && !i_abort && !w_start_req;
            r_tile_row    <= r_row;
            r_tile_col    <= r_col;
            r_tiles_done  <= r_cnt;
        end
    end

    assign o_pipe_en     = r_pipe_en;
    assign o_tile_start  = r_tile_start;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_timeout_err = r_timeout_err;
    assign o_tile_row    = r_tile_row;
    assign o_tile_col    = r_tile_col;
    assign o_tiles_done  = r_tiles_done;

endmodule

// File: tb/tb_mosaic_tile_scheduler.sv
// Directed bench for mosaic_tile_scheduler on a 2x3 grid with an 8-cycle watchdog.
module tb_mosaic_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pipe_done = 1'b0;
    logic       pipe_en, tile_start, busy, frame_done, timeout_err;
    logic [0:0] tile_row;
    logic [1:0] tile_col;
    logic [2:0] tiles_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mosaic_tile_scheduler #(
        .TILE_ROWS     (2),
        .TILE_COLS     (3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_pipe_done  (pipe_done),
        .o_pipe_en    (pipe_en),
        .o_tile_start (tile_start),
        .o_tile_row   (tile_row),
        .o_tile_col   (tile_col),
        .o_tiles_done (tiles_done),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_tile_start"}, tile_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Called on a negedge; returns on the negedge where the first tile_start is visible.
    task automatic start_frame();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    // Entered at the tile_start cycle; returns in the drain-gap cycle.
    task automatic run_tile(input int r, input int c, input int k);
        chk($sformatf("tile_start_%0d_%0d", r, c), tile_start, 1);
        chk("pipe_en_c0", pipe_en, 1);
        chk("tile_row", tile_row, r);
        chk("tile_col", tile_col, c);
        chk("tiles_done_c0", tiles_done, k);
        cyc(1);
        chk("tile_start_c1", tile_start, 0);
        chk("pipe_en_c1", pipe_en, 1);
        cyc(3);
        pipe_done = 1'b1;
        cyc(1);
        pipe_done = 1'b0;
        chk("pipe_en_c5", pipe_en, 1);
        chk("tiles_done_c5", tiles_done, k);
        cyc(1);
        chk("gap_pipe_en", pipe_en, 0);
        chk("tiles_done_c6", tiles_done, k + 1);
        chk("busy_c6", busy, 1);
        chk("frame_done_c6", frame_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        cyc(3);
        chk_quiet("rst");
        chk("rst_tiles_done", tiles_done, 0);
        chk("rst_row", tile_row, 0);
        chk("rst_col", tile_col, 0);
        rst_n = 1'b1;
        cyc(10);
        chk_quiet("idle");
        chk("idle_tiles_done", tiles_done, 0);

        // Full 2x3 frame
        start_frame();
        for (int k = 0; k < 6; k++) begin
            run_tile(k / 3, k % 3, k);
            cyc(1);
        end
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_at_frame_done", busy, 1);
        chk("tiles_done_final", tiles_done, 6);
        chk("tile_start_finish", tile_start, 0);
        cyc(1);
        chk("frame_done_clear", frame_done, 0);
        chk("busy_after_frame", busy, 0);
        chk("tiles_done_hold", tiles_done, 6);
        chk("row_hold", tile_row, 1);
        chk("col_hold", tile_col, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("frame_done_once", frame_done, 0);
        end

        // Abort together with pipe_done during WAIT of tile (0,2)
        start_frame();
        run_tile(0, 0, 0);
        cyc(1);
        run_tile(0, 1, 1);
        cyc(1);
        chk("abort_tile_start", tile_start, 1);
        chk("abort_col", tile_col, 2);
        cyc(1);
        abort = 1'b1;
        pipe_done = 1'b1;
        cyc(1);
        abort = 1'b0;
        pipe_done = 1'b0;
        chk("abort_pipe_en", pipe_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tiles_done", tiles_done, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("abort_no_frame_done", frame_done, 0);
            chk("abort_tiles_hold", tiles_done, 2);
            chk("abort_idle_pipe_en", pipe_en, 0);
        end

        // Stray pipe_done in IDLE
        pipe_done = 1'b1;
        cyc(1);
        pipe_done = 1'b0;
        cyc(1);
        chk("stray_tiles_done", tiles_done, 2);
        chk("stray_busy", busy, 0);
        chk("stray_pipe_en", pipe_en, 0);

        // Watchdog timeout on tile (0,0)
        start_frame();
        chk("to_tile_start", tile_start, 1);
        cyc(8);
        chk("to_last_wait_pipe_en", pipe_en, 1);
        chk("to_not_yet", timeout_err, 0);
        cyc(1);
        chk("to_err", timeout_err, 1);
        chk("to_pipe_en", pipe_en, 0);
        chk("to_busy", busy, 0);
        chk("to_row", tile_row, 0);
        chk("to_col", tile_col, 0);
        cyc(3);
        chk("to_err_sticky", timeout_err, 1);

        // Restart from ERROR, then pipe_done coincident with expiry
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_err_clear", timeout_err, 0);
        cyc(1);
        chk("restart_tile_start", tile_start, 1);
        chk("restart_row", tile_row, 0);
        chk("restart_col", tile_col, 0);
        chk("restart_tiles_done", tiles_done, 0);
        cyc(7);
        pipe_done = 1'b1;
        cyc(1);
        pipe_done = 1'b0;
        chk("tie_pipe_en", pipe_en, 1);
        chk("tie_no_err_a", timeout_err, 0);
        cyc(1);
        chk("tie_gap", pipe_en, 0);
        chk("tie_no_err_b", timeout_err, 0);
        chk("tie_busy", busy, 1);
        chk("tie_tiles_done", tiles_done, 1);
        cyc(1);
        chk("tie_next_tile", tile_start, 1);
        chk("tie_next_col", tile_col, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("tie_abort_busy", busy, 0);

        // Asynchronous reset during WAIT of tile (0,1)
        start_frame();
        run_tile(0, 0, 0);
        cyc(2);
        chk("ar_pre_pipe_en", pipe_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pipe_en", pipe_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_col", tile_col, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk_quiet("ar_idle");
        start_frame();
        chk("ar_restart_tile_start", tile_start, 1);
        chk("ar_restart_row", tile_row, 0);
        chk("ar_restart_col", tile_col, 0);
        chk("ar_restart_tiles_done", tiles_done, 0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
